layer_id_responder: RTL
=======================

// Module: layer_id_responder
// PURPOSE
//  Upper-layer end of the 3D-stack chip-ID assignment link. Watches the 32-bit word driven up from the
//  layer below, qualifies an ID-assignment word, latches this layer's chip_id and link power state,
//  and drives back the acknowledge word the lower layer polls for in its 15-cycle window.
//  One instance per layer, alongside the layer's assigner FSM.
//  Word formats:
//    assign = {HDR[3:0], pwr[3:0], src_id[3:0], new_id[3:0], MAGIC[15:0]}
//    ack    = {ACK_HDR[3:0], rx_power[3:0], chip_id[3:0], src_id[3:0], MAGIC[15:0]}
//  Ack [23:20] == chip_id == the lower layer's chip_id+1, as its checker requires.
// PARAMETERS
//  HDR       4'b1010   header nibble of an assignment word
//  ACK_HDR   4'b0101   header nibble of the acknowledge word
//  MAGIC     16'hBEAF  link magic, both directions
//  MATCH_CNT 2         consecutive identical sampled cycles required to accept a word (1..7)
//  ACK_HOLD  4         cycles the ack word is driven (1..15)
// PORTS
//  clk          in   1   single clock
//  rst_n        in   1   asynchronous, active-low reset
//  f_layer      in   1   1 = bottom layer; block never responds
//  data_in      in   32  word from the layer below, sampled every rising edge, no valid strobe
//  data_out     out  32  ack word while acknowledging, else 0
//  tx_out       out  1   high on every cycle data_out carries the ack
//  sort_finish  out  1   ID assignment complete for this layer (or f_layer)
//  chip_id      out  4   latched ID of this layer
//  id_valid     out  1   chip_id is valid
//  rx_power     out  4   pwr field of the last accepted word
//  id_conflict  out  1   sticky; conflicting reassignment seen (LAYER_RESP_REACK_EN only)
//  reack_cnt    out  4   saturating count of re-acknowledges (LAYER_RESP_REACK_EN only)
// BEHAVIOUR
//  - Reset: all outputs 0, state LISTEN, counters 0. Reset is asynchronous and legal in any state,
//    including mid-ACK; data_out and tx_out drop immediately.
//  - All outputs are registered.
//  - Valid word: [31:28]==HDR, [15:0]==MAGIC, [19:16]==[23:20]+1 (4-bit), and [19:16]!=0.
//    F->0 wrap is therefore rejected; ID 0 belongs to the bottom layer.
//  - LISTEN:
//      valid word sampled -> capture candidate, match=1, go to QUALIFY; if MATCH_CNT==1, go straight to ACK.
//  - QUALIFY:
//      data_in==candidate -> match++; at match==MATCH_CNT, latch chip_id=[19:16] and rx_power=[27:24],
//        then go to ACK.
//      data_in differs and is a valid word -> it becomes the new candidate, match=1.
//      data_in differs and is not valid -> back to LISTEN.
//  - ACK:
//      data_out=ack word and tx_out=1 for exactly ACK_HOLD cycles, then go to DONE.
//      data_in is ignored during ACK.
//  - DONE: data_out=0, tx_out=0, id_valid=1, sort_finish=1. Terminal until reset (but see CONFIGURATION).
//  - Latency: word first sampled at edge k -> ack visible after edge k+MATCH_CNT-1;
//    id_valid rises after ACK_HOLD more edges.
//  - f_layer=1 (static, strapped): chip_id=0, id_valid=1, sort_finish=1 from the first edge after reset.
//    tx_out stays 0 and data_in is ignored.
// CONFIGURATION
//  LAYER_RESP_REACK_EN defined:
//    - In DONE, a qualified valid word whose [19:16] equals chip_id returns to ACK.
//      The lower layer retried at higher power because our ack was missed.
//      On this re-acknowledge, rx_power updates and reack_cnt increments (saturates at 15).
//    - A qualified valid word with a different ID sets id_conflict. chip_id stays unchanged and no ack is sent.
//  LAYER_RESP_REACK_EN undefined:
//    - DONE ignores data_in.
//    - id_conflict and reack_cnt are tied to 0.
// STRUCTURE
//  - Package layer_id_pkg:
//      HDR/ACK_HDR/MAGIC constants, word field bit positions, state enum
//        (LISTEN, QUALIFY, ACK, DONE), function is_assign_word().
//      The same package is shared with the assigner FSM.
//  - Sub-module id_word_qualifier:
//      candidate register plus stability counter; outputs a one-cycle "qualified" pulse and the word.
//      It is reused by LISTEN/QUALIFY and by the DONE re-ack path.
// TESTING
//  1. Reset asserted mid-ACK -> data_out=0, tx_out=0, chip_id=0, id_valid=0 immediately; back to LISTEN.
//  2. 32'hA134BEAF held 2 cycles:
//       data_out=32'h5143BEAF, tx_out=1 for 4 cycles;
//       then chip_id=4, rx_power=1, id_valid=1, sort_finish=1, data_out=0.
//  3. 32'hA134BEAF for 1 cycle, then 32'h0 -> no tx_out; block stays in LISTEN.
//  4. 32'hA135BEAF, 32'hA1F0BEAF, 32'hB134BEAF, each held 3 cycles -> all ignored, no tx_out.
//  5. REACK_EN: after test 2, 32'hA234BEAF held 2 cycles:
//       ack 32'h5243BEAF, reack_cnt=1.
//     Then 32'hA356BEAF held 2 cycles: id_conflict=1, no ack, chip_id stays 4.
//     Macro undefined: no response to either word.
//  6. f_layer=1, any data_in -> chip_id=0, id_valid=1, sort_finish=1, tx_out never asserted.

Source files
------------

// File: rtl/layer_id_pkg.sv
// Shared definitions for the chip-ID assignment link (responder and assigner sides).
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a; the link has no valid or ready signals and words are sampled every cycle.
package layer_id_pkg;

   // Link constants, identical in both directions
   localparam logic [3:0]  HDR     = 4'b1010;
   localparam logic [3:0]  ACK_HDR = 4'b0101;
   localparam logic [15:0] MAGIC   = 16'hBEAF;

   // Default qualification depth and acknowledge length
   localparam int MATCH_CNT_DEF = 2;
   localparam int ACK_HOLD_DEF  = 4;

   // Field positions of the 32-bit link word
   localparam int HDR_LSB = 28;
   localparam int PWR_LSB = 24;
   localparam int SRC_LSB = 20;
   localparam int NEW_LSB = 16;

   typedef enum logic [1:0] {
      LISTEN  = 2'd0,
      QUALIFY = 2'd1,
      ACK     = 2'd2,
      DONE    = 2'd3
   } layer_state_t;

   // Payload of an assignment word (everything between header and magic)
   typedef struct packed {
      logic [3:0] pwr;
      logic [3:0] src_id;
      logic [3:0] new_id;
   } assign_fields_t;

   // Header and magic must match. The new ID must be the sender's ID plus one, and it must
   // not be zero, because ID 0 is reserved for the bottom layer (this rejects the F->0 wrap).
   function automatic logic is_assign_word(input logic [31:0] w);
      logic [3:0] src;
      logic [3:0] nid;
      logic [3:0] src_p1;
      src    = w[SRC_LSB +: 4];
      nid    = w[NEW_LSB +: 4];
      src_p1 = src + 4'd1;
      return (w[HDR_LSB +: 4] == HDR) && (w[15:0] == MAGIC) &&
             (nid == src_p1) && (nid != 4'd0);
   endfunction

   function automatic assign_fields_t get_fields(input logic [31:0] w);
      assign_fields_t f;
      f.pwr    = w[PWR_LSB +: 4];
      f.src_id = w[SRC_LSB +: 4];
      f.new_id = w[NEW_LSB +: 4];
      return f;
   endfunction

   // The ID we report sits at [23:20], which is the field the lower layer checks for its ID plus one
   function automatic logic [31:0] make_ack(input logic [3:0] pwr,
                                            input logic [3:0] chip,
                                            input logic [3:0] src);
      return {ACK_HDR, pwr, chip, src, MAGIC};
   endfunction

endpackage

// File: rtl/id_word_qualifier.sv
// Tracks a candidate assignment word and counts consecutive identical samples of it.
// Latency: qual_o is combinational on the sample that completes MATCH_CNT identical cycles.
// Backpressure: none. Clearing en_i drops the candidate, so the next word must requalify.
module id_word_qualifier
   import layer_id_pkg::*;
#(
   parameter int MATCH_CNT = MATCH_CNT_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en_i,
   input  logic [31:0]    data_i,
   output logic           qual_o,
   output logic           track_o,
   output assign_fields_t fields_o
);

   logic [31:0] cand_q, cand_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        same;
   logic        valid;

   assign same  = (cnt_q != 3'd0) && (data_i == cand_q);
   assign valid = is_assign_word(data_i);

   // Next candidate and count. The pulse fires only on the cycle the count first reaches MATCH_CNT.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      qual_o = 1'b0;
      if (!en_i) begin
         cnt_d = 3'd0;
      end else if (same) begin
         // Once the count has reached MATCH_CNT it stays there, so a held word does not fire again
         if (cnt_q != 3'(MATCH_CNT)) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_d == 3'(MATCH_CNT)) begin
               qual_o = 1'b1;
            end
         end
      end else if (valid) begin
         cand_d = data_i;
         cnt_d  = 3'd1;
         if (MATCH_CNT == 1) begin
            qual_o = 1'b1;
         end
      end else begin
         cnt_d = 3'd0;
      end
   end

   assign track_o  = (cnt_d != 3'd0);
   assign fields_o = get_fields(data_i);

   // Candidate and stability counter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q <= 32'd0;
         cnt_q  <= 3'd0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/layer_id_responder.sv
// Upper-layer responder on the chip-ID link. It qualifies an assignment word, latches the ID, and drives an ack for ACK_HOLD cycles.
// Latency: the ack is registered on the edge that completes qualification; id_valid follows ACK_HOLD edges later.
// Backpressure: none; data_in is sampled on every edge. Optional macro LAYER_RESP_REACK_EN re-acknowledges from DONE.
module layer_id_responder
   import layer_id_pkg::*;
#(
   parameter int MATCH_CNT = MATCH_CNT_DEF,
   parameter int ACK_HOLD  = ACK_HOLD_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_layer,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        tx_out,
   output logic        sort_finish,
   output logic [3:0]  chip_id,
   output logic        id_valid,
   output logic [3:0]  rx_power,
   output logic        id_conflict,
   output logic [3:0]  reack_cnt
);

   layer_state_t   state_q, state_d;
   logic [3:0]     hold_q, hold_d;
   logic [3:0]     chip_id_q, chip_id_d;
   logic [3:0]     rx_power_q, rx_power_d;
   logic [3:0]     src_q, src_d;
   logic [31:0]    data_out_q, data_out_d;
   logic           tx_q, tx_d;
   logic           id_valid_q, id_valid_d;
   logic           sort_q, sort_d;

   logic           qual_en;
   logic           qual;
   logic           track;
   assign_fields_t fields;
   logic           first_accept;
   logic           hold_last;

`ifdef LAYER_RESP_REACK_EN
   logic           conflict_q, conflict_d;
   logic [3:0]     reack_q, reack_d;
   logic           reack_hit;
   logic           reack_miss;

   assign reack_hit  = (state_q == DONE) && qual && (fields.new_id == chip_id_q);
   assign reack_miss = (state_q == DONE) && qual && (fields.new_id != chip_id_q);
`endif

   // The qualifier listens only in states where data_in matters. The bottom layer never listens.
   always_comb begin
      qual_en = 1'b0;
      if (!f_layer) begin
         case (state_q)
            LISTEN, QUALIFY: qual_en = 1'b1;
`ifdef LAYER_RESP_REACK_EN
            DONE:            qual_en = 1'b1;
`endif
            default:         qual_en = 1'b0;
         endcase
      end
   end

   id_word_qualifier #(
      .MATCH_CNT (MATCH_CNT)
   ) u_qual (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (qual_en),
      .data_i   (data_in),
      .qual_o   (qual),
      .track_o  (track),
      .fields_o (fields)
   );

   assign first_accept = qual && ((state_q == LISTEN) || (state_q == QUALIFY));
   assign hold_last    = (hold_q == 4'(ACK_HOLD - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LISTEN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A strapped bottom layer parks in DONE straight out of reset.
   always_comb begin
      state_d = state_q;
      if (f_layer) begin
         state_d = DONE;
      end else begin
         case (state_q)
            LISTEN, QUALIFY: begin
               if (qual) begin
                  state_d = ACK;
               end else if (track) begin
                  state_d = QUALIFY;
               end else begin
                  state_d = LISTEN;
               end
            end
            ACK: begin
               if (hold_last) begin
                  state_d = DONE;
               end
            end
            DONE: begin
`ifdef LAYER_RESP_REACK_EN
               if (reack_hit) begin
                  state_d = ACK;
               end
`endif
            end
            default: state_d = LISTEN;
         endcase
      end
   end

   // Output and datapath next values. Outputs are computed from state_d so each one is registered
   // on the edge that makes the transition.
   always_comb begin
      chip_id_d  = chip_id_q;
      rx_power_d = rx_power_q;
      src_d      = src_q;
      hold_d     = 4'd0;
`ifdef LAYER_RESP_REACK_EN
      conflict_d = conflict_q;
      reack_d    = reack_q;
`endif
      if ((state_q == ACK) && (state_d == ACK)) begin
         hold_d = hold_q + 4'd1;
      end
      if (first_accept) begin
         chip_id_d  = fields.new_id;
         rx_power_d = fields.pwr;
         src_d      = fields.src_id;
      end
`ifdef LAYER_RESP_REACK_EN
      // Same ID again: the lower layer missed our ack and raised its power. Its new power is the one to report.
      if (reack_hit) begin
         rx_power_d = fields.pwr;
         src_d      = fields.src_id;
         if (reack_q != 4'hF) begin
            reack_d = reack_q + 4'd1;
         end
      end
      if (reack_miss) begin
         conflict_d = 1'b1;
      end
`endif
      tx_d       = (state_d == ACK);
      data_out_d = tx_d ? make_ack(rx_power_d, chip_id_d, src_d) : 32'd0;
      // Once set, these stay high through any later re-acknowledge
      id_valid_d = id_valid_q | (state_d == DONE);
      sort_d     = sort_q | (state_d == DONE);
   end

   // Output and datapath registers. Async reset clears the ack at once, even in the middle of ACK.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q     <= 4'd0;
         chip_id_q  <= 4'd0;
         rx_power_q <= 4'd0;
         src_q      <= 4'd0;
         data_out_q <= 32'd0;
         tx_q       <= 1'b0;
         id_valid_q <= 1'b0;
         sort_q     <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         chip_id_q  <= chip_id_d;
         rx_power_q <= rx_power_d;
         src_q      <= src_d;
         data_out_q <= data_out_d;
         tx_q       <= tx_d;
         id_valid_q <= id_valid_d;
         sort_q     <= sort_d;
      end
   end

`ifdef LAYER_RESP_REACK_EN
   // Re-acknowledge bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_q <= 1'b0;
         reack_q    <= 4'd0;
      end else begin
         conflict_q <= conflict_d;
         reack_q    <= reack_d;
      end
   end

   assign id_conflict = conflict_q;
   assign reack_cnt   = reack_q;
`else
   assign id_conflict = 1'b0;
   assign reack_cnt   = 4'd0;
`endif

   assign data_out    = data_out_q;
   assign tx_out      = tx_q;
   assign sort_finish = sort_q;
   assign chip_id     = chip_id_q;
   assign id_valid    = id_valid_q;
   assign rx_power    = rx_power_q;

endmodule
